// File: rtl/tff_cnt_pkg.sv
// tff_cnt_pkg: shared constants, action encoding and load clamp for tff_mod_counter
package tff_cnt_pkg;
  localparam int unsigned TCNT_MAX_WIDTH = 16;
  typedef enum logic [1:0] {ACT_CLR, ACT_LD, ACT_CNT, ACT_HOLD} act_e;
  function automatic int unsigned tcnt_clamp(input int unsigned value, input int unsigned modulus);
    return value < modulus ? value : modulus - 1;
  endfunction
endpackage

// File: rtl/tff_bit.sv
// tff_bit: single T flip-flop with async active-high reset to 0
module tff_bit (
  input  logic clk,
  input  logic t,
  input  logic re,
  output logic q
);
  always_ff @(posedge clk or posedge re)
    if (re) q <= 1'b0;
    else q <= q ^ t;
endmodule

// File: rtl/tff_mod_counter.sv
// tff_mod_counter: modulo-N counter built from T cells; TCNT_UPDOWN_EN adds the up port and down counting
module tff_mod_counter
  import tff_cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             re,
  input  logic             t,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
`ifdef TCNT_UPDOWN_EN
  input  logic             up,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  if (WIDTH < 1 || WIDTH > TCNT_MAX_WIDTH) begin : g_bad_width
    $error("tff_mod_counter: WIDTH out of range");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("tff_mod_counter: MODULUS out of range");
  end
  act_e act;
  logic [WIDTH-1:0] up_nxt, step, ld_val, nxt, tgl;
  logic wrap_up, wrap, ovf_nxt;
  assign act = clr ? ACT_CLR : ld ? ACT_LD : t ? ACT_CNT : ACT_HOLD;
  // out-of-range values also take the up wrap back to 0
  assign wrap_up = 32'(q) >= MODULUS - 1;
  assign up_nxt  = wrap_up ? '0 : q + 1'b1;
  assign ld_val  = WIDTH'(tcnt_clamp(32'(d), MODULUS));
`ifdef TCNT_UPDOWN_EN
  logic [WIDTH-1:0] dn_nxt;
  assign dn_nxt = (q == '0) ? MAXV : (32'(q) >= MODULUS) ? MAXV - 1'b1 : q - 1'b1;
  assign step   = up ? up_nxt : dn_nxt;
  assign wrap   = up ? wrap_up : q == '0;
  assign tc     = t & (up ? q == MAXV : q == '0);
`else
  assign step   = up_nxt;
  assign wrap   = wrap_up;
  assign tc     = t & (q == MAXV);
`endif
  always_comb begin
    nxt     = act == ACT_CLR ? '0 : act == ACT_LD ? ld_val : act == ACT_CNT ? step : q;
    ovf_nxt = act == ACT_CLR ? 1'b0 : act == ACT_CNT ? (ovf | wrap) : ovf;
  end
  assign tgl = q ^ nxt;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_bit u_bit (.clk(clk), .t(tgl[i]), .re(re), .q(q[i]));
  end
  always_ff @(posedge clk or posedge re)
    if (re) ovf <= 1'b0;
    else ovf <= ovf_nxt;
endmodule

// File: tb/tb_tff_mod_counter.sv
// tb_tff_mod_counter: directed table, hand sequences and random run against a reference model
module tb_tff_mod_counter;
`ifdef TCNT_UPDOWN_EN
  localparam bit HAS_UD = 1'b1;
`else
  localparam bit HAS_UD = 1'b0;
`endif
  localparam int M = 10;
  logic clk = 1'b0, re = 1'b0, t = 1'b0, clr = 1'b0, ld = 1'b0, up = 1'b1;
  logic [3:0] d = '0, q;
  logic tc, ovf;
  logic b_re = 1'b0, b_t = 1'b0;
  logic [2:0] b_q;
  logic b_tc, b_ovf;
  int tests = 0, fails = 0;
  int mq = 0, movf = 0;
  always #5 clk = ~clk;
  tff_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .re(re), .t(t), .clr(clr), .ld(ld), .d(d),
`ifdef TCNT_UPDOWN_EN
    .up(up),
`endif
    .q(q), .tc(tc), .ovf(ovf));
  tff_mod_counter #(.WIDTH(3), .MODULUS(8)) dut_b (
    .clk(clk), .re(b_re), .t(b_t), .clr(1'b0), .ld(1'b0), .d(3'd0),
`ifdef TCNT_UPDOWN_EN
    .up(1'b1),
`endif
    .q(b_q), .tc(b_tc), .ovf(b_ovf));
  typedef struct {
    bit c, l, tt, u;
    int dd, eq, eovf, etc;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int model_tc();
    bit eu = HAS_UD ? up : 1'b1;
    return int'(t && (eu ? mq == M - 1 : mq == 0));
  endfunction
  task automatic model_step();
    bit eu = HAS_UD ? up : 1'b1;
    if (clr) begin
      mq = 0; movf = 0;
    end else if (ld) mq = (int'(d) < M) ? int'(d) : M - 1;
    else if (t) begin
      if (eu) begin
        if (mq >= M - 1) begin mq = 0; movf = 1; end
        else mq = mq + 1;
      end else begin
        if (mq == 0) begin mq = M - 1; movf = 1; end
        else if (mq >= M) mq = M - 2;
        else mq = mq - 1;
      end
    end
  endtask
  task automatic drive(input bit c, input bit l, input bit tt, input bit u, input int dd);
    clr = c; ld = l; t = tt; up = u; d = 4'(dd);
  endtask
  task automatic cyc(input bit c, input bit l, input bit tt, input bit u, input int dd);
    drive(c, l, tt, u, dd);
    @(negedge clk);
    chk("tc_model", int'(tc), model_tc());
    model_step();
    @(posedge clk); #1;
    chk("q_model", int'(q), mq);
    chk("ovf_model", int'(ovf), movf);
  endtask
  function automatic vec_t mk(bit c, bit l, bit tt, bit u, int dd, int eq, int eovf, int etc);
    vec_t v;
    v.c = c; v.l = l; v.tt = tt; v.u = u; v.dd = dd; v.eq = eq; v.eovf = eovf; v.etc = etc;
    return v;
  endfunction
  initial begin
    for (int i = 0; i < 12; i++) vecs.push_back(mk(0, 0, 1, 1, 0, (i + 1) % 10, int'(i >= 9), int'(i % 10 == 9)));
    vecs.push_back(mk(0, 1, 0, 1, 7, 7, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 13, 9, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 3, 3, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, 5, 5, 1, 0));
    vecs.push_back(mk(1, 1, 1, 1, 8, 0, 0, 0));
    if (HAS_UD) begin
      vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 9, 1, 1));
      vecs.push_back(mk(0, 0, 1, 0, 0, 8, 1, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 9, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 8, 1, 0));
    end
    #3 re = 1'b1; b_re = 1'b1;
    #1;
    chk("reset_q", int'(q), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_b_q", int'(b_q), 0);
    @(posedge clk); #1;
    chk("reset_hold_q", int'(q), 0);
    re = 1'b0; b_re = 1'b0;
    mq = 0; movf = 0;
    foreach (vecs[i]) begin
      drive(vecs[i].c, vecs[i].l, vecs[i].tt, vecs[i].u, vecs[i].dd);
      @(negedge clk);
      chk($sformatf("vec%0d_tc", i), int'(tc), vecs[i].etc);
      model_step();
      @(posedge clk); #1;
      chk($sformatf("vec%0d_q", i), int'(q), vecs[i].eq);
      chk($sformatf("vec%0d_ovf", i), int'(ovf), vecs[i].eovf);
    end
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
          HAS_UD ? 1'($urandom_range(1)) : 1'b1, int'($urandom_range(15)));
    cyc(0, 1, 0, 1, 6);
    drive(0, 0, 1, 1, 0);
    #2 re = 1'b1;
    #1;
    chk("async_q", int'(q), 0);
    chk("async_ovf", int'(ovf), 0);
    mq = 0; movf = 0;
    @(posedge clk); #1;
    chk("async_held_q", int'(q), 0);
    re = 1'b0;
    cyc(0, 0, 1, 1, 0);
    chk("resume_q", int'(q), 1);
    drive(0, 0, 0, 1, 0);
    b_t = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bin%0d_tc", i), int'(b_tc), int'(i % 8 == 7));
      @(posedge clk); #1;
      chk($sformatf("bin%0d_q", i), int'(b_q), (i + 1) % 8);
      chk($sformatf("bin%0d_ovf", i), int'(b_ovf), int'(i >= 7));
    end
    b_t = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
